act_func_arbiter: RTL and testbench

//   Round-robin arbiter and 2-stage pipeline that shares one LUT+interpolator

---
 rtl/act_func_arbiter.sv | 99 +++++++++
 tb/tb_act_func_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/act_func_arbiter.sv
// Round-robin arbiter feeding one shared combinational activation unit through a
// 2-stage pipeline (operand register, tagged response register with valid/ready).
module act_func_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_z,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       func_z,
  input  logic [DATA_W-1:0]       func_a,
  output logic                    rsp_valid,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [DATA_W-1:0]       rsp_a,
  input  logic                    rsp_ready
);

  localparam logic [TAG_W:0]   N_REQ_W  = (TAG_W+1)'(N_REQ);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N_REQ - 1);

  logic [DATA_W-1:0] z_arr [N_REQ];
  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_valid;
  logic [TAG_W-1:0]  grant_idx;
  logic              grant_found;
  logic              s1_free;
  logic              s2_free;
  logic              accept;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign z_arr[i] = req_z[i*DATA_W +: DATA_W];
  end

  // A stage may load when it is empty or its contents move on this same edge.
  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1_valid || s2_free;

  always_comb begin : arbitrate
    logic [TAG_W:0] idx;
    // NOTE: every variable gets a default before the search so no path infers a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (TAG_W+1)'(i);
      if (idx >= N_REQ_W) idx = idx - N_REQ_W;
      if (!grant_found && req_valid[idx[TAG_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[TAG_W-1:0];
      end
    end
  end

  // Reset gates the grant combinationally so nothing is accepted while rst is low.
  assign accept = rst && grant_found && s1_free;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // NOTE: all pipeline state uses non-blocking assignments so both stages see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rr_ptr    <= '0;
      func_z    <= '0;
      s1_tag    <= '0;
      rsp_tag   <= '0;
      rsp_a     <= '0;
    end else begin
      if (s2_free) begin
        if (s1_valid) begin
          rsp_a     <= func_a;
          rsp_tag   <= s1_tag;
          rsp_valid <= 1'b1;
        end else begin
          rsp_valid <= 1'b0;
        end
      end
      if (s1_free) begin
        if (accept) begin
          func_z   <= z_arr[grant_idx];
          s1_tag   <= grant_idx;
          s1_valid <= 1'b1;
          rr_ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end else begin
          s1_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_func_arbiter.sv
// Self-checking bench for act_func_arbiter: directed scenarios plus random traffic,
// compared against a queue-based model of in-flight results.
module tb_act_func_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_z;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    func_z;
  logic [W-1:0]    func_a;
  logic            rsp_valid;
  logic [TW-1:0]   rsp_tag;
  logic [W-1:0]    rsp_a;
  logic            rsp_ready;

  always #5 clk = ~clk;

  // Stand-in activation unit.
  assign func_a = func_z + 8'd1;

  act_func_arbiter #(.N_REQ(N), .DATA_W(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_z(req_z), .req_ready(req_ready),
    .func_z(func_z), .func_a(func_a),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_a(rsp_a), .rsp_ready(rsp_ready)
  );

  typedef struct {
    int         tag;
    logic [7:0] a;
    bit         out;   // sitting in the response register
  } item_t;

  item_t      q[$];
  int         ptr;
  logic [7:0] m_func_z;
  int         last_tag;
  logic [7:0] last_a;
  int         m_g;
  bit         m_acc;
  logic [N-1:0] obs_ready;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, advance the model, step past the edge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    logic [7:0]   z;
    bit           room;
    @(negedge clk);
    obs_ready = req_ready;
    m_g   = pick(req_valid, ptr);
    room  = (q.size() < 2) || rsp_ready;
    m_acc = rst && (m_g >= 0) && room;
    exp_ready = m_acc ? N'(1 << m_g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0 && q[0].out));
    check("rsp_tag",   32'(rsp_tag),   32'(last_tag));
    check("rsp_a",     32'(rsp_a),     32'(last_a));
    check("func_z",    32'(func_z),    32'(m_func_z));
    if (!rst) begin
      q.delete();
      ptr = 0; m_func_z = '0; last_tag = 0; last_a = '0;
    end else begin
      if (q.size() > 0 && q[0].out && rsp_ready) void'(q.pop_front());
      if (q.size() > 0 && !q[0].out) begin
        q[0].out = 1'b1;
        last_tag = q[0].tag;
        last_a   = q[0].a;
      end
      if (m_acc) begin
        z = req_z[m_g*W +: W];
        q.push_back('{tag: m_g, a: 8'(z + 8'd1), out: 1'b0});
        m_func_z = z;
        ptr = (m_g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] pend;
  logic [7:0]   zval [N];
  logic [N-1:0] prev_ready;
  int           grants;

  initial begin
    rst = 1'b0; req_valid = '0; req_z = '0; rsp_ready = 1'b1;
    ptr = 0; m_func_z = '0; last_tag = 0; last_a = '0;
    @(posedge clk); #1;
    cycle();
    rst = 1'b1;

    // Single request from requester 0.
    req_valid = 4'b0001; req_z = {24'h0, 8'h25};
    cycle();
    check("t1_func_z", 32'(func_z), 32'h25);
    req_valid = '0;
    cycle();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_tag",   32'(rsp_tag),   32'd0);
    check("t1_rsp_a",     32'(rsp_a),     32'h26);

    // All four requesting continuously.
    req_valid = 4'b1111; req_z = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (10) cycle();

    // Drain, then backpressure with everyone requesting.
    req_valid = '0;
    repeat (3) cycle();
    req_valid = 4'b1111; rsp_ready = 1'b0; grants = 0;
    repeat (4) begin
      cycle();
      if (obs_ready != '0) grants++;
    end
    check("t3_accepts", 32'(grants), 32'd2);
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) cycle();

    // Fairness between requesters 1 and 3.
    req_valid = 4'b1010; prev_ready = '0;
    repeat (8) begin
      cycle();
      if (prev_ready != '0) check("t4_alternate", 32'(obs_ready != prev_ready), 32'd1);
      prev_ready = obs_ready;
    end

    // Reset with both stages full.
    req_valid = 4'b1111;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("t5_rst_ready", 32'(obs_ready), 32'd0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1; req_valid = 4'b0110;
    cycle();
    check("t5_first_grant", 32'(obs_ready), 32'b0010);
    req_valid = '0;
    repeat (3) cycle();

    // Signed extremes pass through bit-exact.
    req_valid = 4'b0001; req_z = {24'h0, 8'h80};
    cycle();
    check("t6_func_z_80", 32'(func_z), 32'h80);
    req_z = {24'h0, 8'h7F};
    cycle();
    check("t6_func_z_7f", 32'(func_z), 32'h7F);
    check("t6_rsp_a_81",  32'(rsp_a),  32'h81);
    req_valid = '0;
    cycle();
    check("t6_rsp_a_80",  32'(rsp_a),  32'h80);
    repeat (2) cycle();

    // Random traffic; requesters hold z until granted.
    pend = '0;
    for (int i = 0; i < N; i++) zval[i] = '0;
    repeat (500) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          zval[i] = 8'($urandom);
        end
        req_z[i*W +: W] = zval[i];
      end
      req_valid = pend;
      rsp_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 97) != 0;
      cycle();
      if (m_acc) pend[m_g] = 1'b0;
    end

    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
